// File: rtl/approx_adder_err_sequencer.sv
// Error-characterization sequencer for an external combinational approximate adder.
//
// This block drives operand pairs into the adder under test and samples the
// adder's result. It compares each result against the exact sum and
// accumulates the error count, the maximum absolute error and the sum of
// squared errors. Software divides sum_sq_err by the sample count to get the MSE.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle run request, honoured in IDLE or DONE
//   mode         0 = exhaustive sweep, 1 = LFSR random (sampled on start)
//   seed         LFSR seed, sampled on start (0 is replaced by 1)
//   num_samples  LFSR-mode sample count, sampled on start (0 means 1)
//   op_a, op_b   registered operands to the adder's IN1/IN2
//   approx_sum   adder Out, combinational from op_a/op_b
//   busy         high in RUN and DRAIN
//   done         high in DONE until the next start
//   err_count    samples with a wrong result (saturating)
//   max_abs_err  largest |approx_sum - exact| in the run
//   sum_sq_err   sum of squared errors (saturating)
//   samples_done compares retired in the run (wrapping)
module approx_adder_err_sequencer #(
  parameter int                 WIDTH     = 16,
  parameter logic [2*WIDTH-1:0] LFSR_TAPS = 32'h8020_0003,
  parameter int                 ACC_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   seed,
  input  logic [31:0]          num_samples,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH:0]       approx_sum,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          err_count,
  output logic [WIDTH:0]       max_abs_err,
  output logic [ACC_W-1:0]     sum_sq_err,
  output logic [31:0]          samples_done
);

  localparam int GW = 2 * WIDTH;
  localparam int SW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam int QW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            armed;
  logic            mode_r;
  logic [31:0]     num_r;
  logic [31:0]     issued;
  logic            last_iss;
  logic [GW-1:0]   gen;
  logic            vld_p0, vld_p1;
  logic            start_ok, issue;

  logic [SW-1:0]        sum_p1;
  logic [WIDTH-1:0]     a_p1, b_p1;
  logic [SW-1:0]        exact_p1;
  logic signed [EW-1:0] err_p1, mag_p1;
  logic [SW-1:0]        abs_p1;
  logic [QW-1:0]        sq_p1;

  function automatic logic [GW-1:0] lfsr_step(input logic [GW-1:0] g);
    return (g >> 1) ^ (g[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                               input logic [QW-1:0]    sq);
    logic [ACC_W:0] t;
    t = {1'b0, acc} + (ACC_W+1)'(sq);
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  // armed blocks a start that coincides with the first edge after reset release
  assign start_ok = start && armed && (state == S_IDLE || state == S_DONE);
  assign issue    = (state == S_RUN) && !last_iss;

  // State register and control path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      mode_r   <= 1'b0;
      num_r    <= '0;
      issued   <= '0;
      last_iss <= 1'b0;
      gen      <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      state  <= state_nxt;
      armed  <= 1'b1;
      vld_p0 <= issue;
      vld_p1 <= vld_p0;
      if (start_ok) begin
        mode_r   <= mode;
        num_r    <= (num_samples == 32'd0) ? 32'd1 : num_samples;
        gen      <= mode ? ((seed == '0) ? GW'(1) : seed) : '0;
        issued   <= '0;
        last_iss <= 1'b0;
      end else if (issue) begin
        {op_b, op_a} <= gen;
        gen          <= mode_r ? lfsr_step(gen) : gen + GW'(1);
        issued       <= issued + 32'd1;
        // exhaustive sweep stops on the all-ones pair, never wrapping to a second pass
        last_iss     <= mode_r ? (issued + 32'd1 == num_r) : (&gen);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (last_iss) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state == S_RUN || state == S_DRAIN) busy = 1'b1;
    if (state == S_DONE)                    done = 1'b1;
  end

  // Stage 1: capture the settled adder output with the operands that produced it
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sum_p1 <= approx_sum;
      a_p1   <= op_a;
      b_p1   <= op_b;
    end
  end

  assign exact_p1 = {1'b0, a_p1} + {1'b0, b_p1};
  assign err_p1   = $signed({1'b0, sum_p1}) - $signed({1'b0, exact_p1});
  assign mag_p1   = err_p1[EW-1] ? -err_p1 : err_p1;
  assign abs_p1   = SW'(mag_p1);
  assign sq_p1    = QW'(abs_p1) * QW'(abs_p1);

  // Stage 2: statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      max_abs_err  <= '0;
      sum_sq_err   <= '0;
      samples_done <= '0;
    end else if (start_ok) begin
      err_count    <= '0;
      max_abs_err  <= '0;
      sum_sq_err   <= '0;
      samples_done <= '0;
    end else if (vld_p1) begin
      if (err_p1 != '0)          err_count   <= sat_inc(err_count);
      if (abs_p1 > max_abs_err)  max_abs_err <= abs_p1;
      sum_sq_err   <= sat_acc(sum_sq_err, sq_p1);
      samples_done <= samples_done + 32'd1;
    end
  end

endmodule

// File: tb/tb_approx_adder_err_sequencer.sv
module tb_approx_adder_err_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  // WIDTH = 16 instance
  logic        start, mode;
  logic [31:0] seed, num;
  logic [15:0] op_a, op_b;
  logic [16:0] approx_sum;
  logic        busy, done;
  logic [31:0] err_count, samples_done;
  logic [16:0] max_abs_err;
  logic [63:0] sum_sq_err;
  int          model_sel = 0;

  // WIDTH = 4 instance
  logic        start4, mode4;
  logic [7:0]  seed4;
  logic [31:0] num4;
  logic [3:0]  op_a4, op_b4;
  logic [4:0]  approx4, sum5;
  logic        busy4, done4;
  logic [31:0] err4, samp4;
  logic [4:0]  max4;
  logic [63:0] sq4;

  int checks = 0;
  int errors = 0;

  // Reference results
  int          r_cnt, r_max, r_n;
  longint      r_sq;
  logic [15:0] r_fa, r_fb, r_la, r_lb;

  approx_adder_err_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .num_samples(num), .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .err_count(err_count), .max_abs_err(max_abs_err),
    .sum_sq_err(sum_sq_err), .samples_done(samples_done)
  );

  approx_adder_err_sequencer #(.WIDTH(4), .LFSR_TAPS(8'hB8), .ACC_W(64)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .seed(seed4),
    .num_samples(num4), .op_a(op_a4), .op_b(op_b4), .approx_sum(approx4),
    .busy(busy4), .done(done4), .err_count(err4), .max_abs_err(max4),
    .sum_sq_err(sq4), .samples_done(samp4)
  );

  // Adder models: 0 exact, 1 stuck at zero, 2 lower-part OR on 4 LSBs
  function automatic logic [16:0] model_fn(input logic [15:0] a, input logic [15:0] b, input int m);
    logic [12:0] hi;
    if (m == 0) return {1'b0, a} + {1'b0, b};
    if (m == 1) return 17'd0;
    hi = {1'b0, a[15:4]} + {1'b0, b[15:4]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  always_comb approx_sum = model_fn(op_a, op_b, model_sel);

  always_comb begin
    sum5    = {1'b0, op_a4} + {1'b0, op_b4};
    approx4 = {sum5[4:1], 1'b0};
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] g);
    return (g >> 1) ^ (g[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference: walk the LFSR sequence and accumulate statistics with plain integers
  task automatic ref_lfsr(input logic [31:0] s, input logic [31:0] n, input int m);
    logic [31:0] g;
    int ex, ap, e, ab;
    g = (s == 0) ? 32'd1 : s;
    r_n = (n == 0) ? 1 : int'(n);
    r_cnt = 0; r_max = 0; r_sq = 0;
    r_fa = g[15:0]; r_fb = g[31:16];
    for (int i = 0; i < r_n; i++) begin
      ex = int'(g[15:0]) + int'(g[31:16]);
      ap = int'(model_fn(g[15:0], g[31:16], m));
      e  = ap - ex;
      ab = (e < 0) ? -e : e;
      if (e != 0) r_cnt++;
      if (ab > r_max) r_max = ab;
      r_sq += longint'(ab) * longint'(ab);
      r_la = g[15:0]; r_lb = g[31:16];
      g = lfsr_next(g);
    end
  endtask

  task automatic start_run(input logic m, input logic [31:0] s, input logic [31:0] n);
    @(negedge clk);
    mode = m; seed = s; num = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; cyc is the number of edges after the start edge (0 on timeout)
  task automatic wait_done(input int bound, input int intr_at, output int cyc,
                           output logic [15:0] fa, output logic [15:0] fb, output logic b1);
    cyc = 0; fa = '0; fb = '0; b1 = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin fa = op_a; fb = op_b; b1 = busy; end
      if (intr_at > 0 && c == intr_at) begin start = 1'b1; mode = 1'b0; seed = $urandom; num = 32'd7; end
      if (intr_at > 0 && c == intr_at + 1) start = 1'b0;
      if (done) begin cyc = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({op_a, op_b, err_count, max_abs_err, sum_sq_err, samples_done} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {op_a, op_b, err_count, max_abs_err, sum_sq_err, samples_done}); end
    checks++; if ({busy, done, busy4, done4} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, busy4, done4}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done} !== 2'b0) begin
      errors++; $display("FAIL idle_after_reset got %b exp 00", {busy, done}); end
  endtask

  task automatic test_exact();
    int cyc; logic [15:0] fa, fb; logic b1;
    model_sel = 0;
    ref_lfsr(32'h0001_0001, 32'd1000, 0);
    start_run(1'b1, 32'h0001_0001, 32'd1000);
    wait_done(3000, 0, cyc, fa, fb, b1);
    checks++; if (cyc !== 1002) begin errors++; $display("FAIL exact_latency got %0d exp 1002", cyc); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL exact_busy got %b exp 1", b1); end
    checks++; if ({fb, fa} !== {r_fb, r_fa}) begin errors++; $display("FAIL exact_first_pair got %h exp %h", {fb, fa}, {r_fb, r_fa}); end
    checks++; if ({err_count, max_abs_err, sum_sq_err} !== '0) begin
      errors++; $display("FAIL exact_stats got %0d %0d %0d exp 0 0 0", err_count, max_abs_err, sum_sq_err); end
    checks++; if (samples_done !== 32'd1000) begin errors++; $display("FAIL exact_samples got %0d exp 1000", samples_done); end
    repeat (5) @(posedge clk); #1;
    checks++; if ({done, busy, samples_done} !== {1'b1, 1'b0, 32'd1000}) begin
      errors++; $display("FAIL done_hold got done=%b busy=%b samples=%0d exp 1 0 1000", done, busy, samples_done); end
    checks++; if ({op_b, op_a} !== {r_lb, r_la}) begin
      errors++; $display("FAIL ops_hold got %h exp %h", {op_b, op_a}, {r_lb, r_la}); end
  endtask

  task automatic test_stuck_zero();
    int cyc; logic [15:0] fa, fb; logic b1;
    model_sel = 1;
    ref_lfsr(32'h0001_0001, 32'd1, 1);
    start_run(1'b1, 32'h0001_0001, 32'd1);
    wait_done(100, 0, cyc, fa, fb, b1);
    checks++; if ({fa, fb} !== {16'h0001, 16'h0001}) begin errors++; $display("FAIL stuck_first_pair got %h exp 00010001", {fa, fb}); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL stuck_latency got %0d exp 3", cyc); end
    checks++; if ({err_count, max_abs_err, sum_sq_err} !== {32'(r_cnt), 17'(r_max), 64'(r_sq)}) begin
      errors++; $display("FAIL stuck_stats got %0d %0d %0d exp %0d %0d %0d", err_count, max_abs_err, sum_sq_err, r_cnt, r_max, r_sq); end
  endtask

  task automatic test_seed_zero();
    int cyc; logic [15:0] fa, fb; logic b1;
    model_sel = 1;
    ref_lfsr(32'h0, 32'd1, 1);
    start_run(1'b1, 32'h0, 32'd1);
    wait_done(100, 0, cyc, fa, fb, b1);
    checks++; if ({fa, fb} !== {16'h0001, 16'h0000}) begin errors++; $display("FAIL seed0_first_pair got %h exp 00010000", {fa, fb}); end
    checks++; if ({err_count, sum_sq_err} !== {32'(r_cnt), 64'(r_sq)}) begin
      errors++; $display("FAIL seed0_stats got %0d %0d exp %0d %0d", err_count, sum_sq_err, r_cnt, r_sq); end
  endtask

  task automatic test_num_zero();
    int cyc; logic [15:0] fa, fb; logic b1;
    model_sel = 2;
    ref_lfsr(32'hBEEF_1234, 32'd0, 2);
    start_run(1'b1, 32'hBEEF_1234, 32'd0);
    wait_done(100, 0, cyc, fa, fb, b1);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL num0_latency got %0d exp 3", cyc); end
    checks++; if ({samples_done, err_count, sum_sq_err} !== {32'd1, 32'(r_cnt), 64'(r_sq)}) begin
      errors++; $display("FAIL num0_stats got %0d %0d %0d exp 1 %0d %0d", samples_done, err_count, sum_sq_err, r_cnt, r_sq); end
  endtask

  task automatic test_random();
    int cyc; logic [15:0] fa, fb; logic b1;
    logic [31:0] s, n;
    for (int it = 0; it < 5; it++) begin
      s = $urandom; n = $urandom_range(300, 1);
      model_sel = (it == 0) ? 2 : int'($urandom_range(2, 0));
      ref_lfsr(s, n, model_sel);
      start_run(1'b1, s, n);
      wait_done(1000, 0, cyc, fa, fb, b1);
      checks++; if (cyc !== r_n + 2) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", it, cyc, r_n + 2); end
      checks++; if ({fb, fa} !== {r_fb, r_fa}) begin errors++; $display("FAIL rand%0d_first_pair got %h exp %h", it, {fb, fa}, {r_fb, r_fa}); end
      checks++; if (err_count !== 32'(r_cnt)) begin errors++; $display("FAIL rand%0d_err_count got %0d exp %0d", it, err_count, r_cnt); end
      checks++; if (max_abs_err !== 17'(r_max)) begin errors++; $display("FAIL rand%0d_max got %0d exp %0d", it, max_abs_err, r_max); end
      checks++; if (sum_sq_err !== 64'(r_sq)) begin errors++; $display("FAIL rand%0d_sumsq got %0d exp %0d", it, sum_sq_err, r_sq); end
      checks++; if (samples_done !== 32'(r_n)) begin errors++; $display("FAIL rand%0d_samples got %0d exp %0d", it, samples_done, r_n); end
    end
  endtask

  task automatic test_restart_ignored();
    int cyc; logic [15:0] fa, fb; logic b1;
    logic [31:0] s;
    s = $urandom;
    model_sel = 2;
    ref_lfsr(s, 32'd1000, 2);
    start_run(1'b1, s, 32'd1000);
    wait_done(3000, 500, cyc, fa, fb, b1);
    checks++; if (cyc !== 1002) begin errors++; $display("FAIL restart_latency got %0d exp 1002", cyc); end
    checks++; if ({err_count, max_abs_err, sum_sq_err, samples_done} !== {32'(r_cnt), 17'(r_max), 64'(r_sq), 32'd1000}) begin
      errors++; $display("FAIL restart_stats got %0d %0d %0d %0d exp %0d %0d %0d 1000",
                         err_count, max_abs_err, sum_sq_err, samples_done, r_cnt, r_max, r_sq); end
  endtask

  task automatic test_abort();
    int cyc; logic [15:0] fa, fb; logic b1;
    logic [31:0] s;
    model_sel = 2;
    start_run(1'b1, 32'h1357_9BDF, 32'd1000);
    repeat (300) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if ({op_a, op_b, busy, done, err_count, max_abs_err, sum_sq_err, samples_done} !== '0) begin
      errors++; $display("FAIL abort_outputs got busy=%b done=%b samples=%0d err=%0d exp all 0", busy, done, samples_done, err_count); end
    repeat (2) @(negedge clk);
    // release reset with start already high: that start must be ignored
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, samples_done} !== '0) begin
      errors++; $display("FAIL start_at_release got busy=%b done=%b samples=%0d exp 0 0 0", busy, done, samples_done); end
    s = $urandom;
    model_sel = 1;
    ref_lfsr(s, 32'd50, 1);
    start_run(1'b1, s, 32'd50);
    wait_done(500, 0, cyc, fa, fb, b1);
    checks++; if (cyc !== 52) begin errors++; $display("FAIL after_abort_latency got %0d exp 52", cyc); end
    checks++; if ({err_count, max_abs_err, sum_sq_err, samples_done} !== {32'(r_cnt), 17'(r_max), 64'(r_sq), 32'd50}) begin
      errors++; $display("FAIL after_abort_stats got %0d %0d %0d %0d exp %0d %0d %0d 50",
                         err_count, max_abs_err, sum_sq_err, samples_done, r_cnt, r_max, r_sq); end
  endtask

  task automatic test_exhaustive_w4();
    int cyc, e_cnt, e_max, s, ap, e, ab;
    longint e_sq;
    logic [7:0] p1, p2;
    e_cnt = 0; e_max = 0; e_sq = 0; cyc = 0; p1 = '1; p2 = '1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        s  = a + b;
        ap = (s / 2) * 2;
        e  = ap - s;
        ab = (e < 0) ? -e : e;
        if (e != 0) e_cnt++;
        if (ab > e_max) e_max = ab;
        e_sq += longint'(ab * ab);
      end
    @(negedge clk);
    mode4 = 1'b0; seed4 = 8'h5A; num4 = 32'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (c == 1) p1 = {op_b4, op_a4};
      if (c == 2) p2 = {op_b4, op_a4};
      if (done4) begin cyc = c; break; end
    end
    checks++; if (cyc !== 258) begin errors++; $display("FAIL w4_latency got %0d exp 258", cyc); end
    checks++; if ({p1, p2} !== 16'h0001) begin errors++; $display("FAIL w4_first_pairs got %h exp 0001", {p1, p2}); end
    checks++; if ({op_b4, op_a4} !== 8'hFF) begin errors++; $display("FAIL w4_last_pair got %h exp ff", {op_b4, op_a4}); end
    checks++; if ({err4, max4, sq4, samp4} !== {32'(e_cnt), 5'(e_max), 64'(e_sq), 32'd256}) begin
      errors++; $display("FAIL w4_stats got %0d %0d %0d %0d exp %0d %0d %0d 256", err4, max4, sq4, samp4, e_cnt, e_max, e_sq); end
  endtask

  initial begin
    start = 1'b0; mode = 1'b0; seed = '0; num = '0;
    start4 = 1'b0; mode4 = 1'b0; seed4 = '0; num4 = '0;
    test_reset();
    test_exact();
    test_stuck_zero();
    test_seed_zero();
    test_num_zero();
    test_random();
    test_restart_ignored();
    test_abort();
    test_exhaustive_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
